// File: rtl/vram_scan_arbiter_if.sv
// rtl/vram_scan_arbiter_if.sv - fetch, line-buffer, host and VRAM signals of the scan arbiter
interface vram_scan_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int LB_AW  = 8
) ();
  logic              fetch_start;
  logic [9:0]        fetch_line;
  logic              fetch_busy;
  logic              fetch_done;
  logic              fetch_overrun;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output fetch_start, fetch_line, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    input  fetch_busy, fetch_done, fetch_overrun, lb_we, lb_addr, lb_wdata,
           host_ready, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  fetch_start, fetch_line, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    output fetch_busy, fetch_done, fetch_overrun, lb_we, lb_addr, lb_wdata,
           host_ready, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - VRAM arbiter: scanline prefetch bursts with priority, host served when idle
module vram_scan_arbiter #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 200,
  parameter int LB_AW          = 8
) (
  input logic              clk,
  input logic              rst,
  vram_scan_arbiter_if.slave bus
);
  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LB_AW-1:0]  idx_q, idx_d;
  logic [LB_AW-1:0]  tag_idx_q, tag_idx_d;
  logic              tag_fetch_q, tag_fetch_d;
  logic              tag_host_q, tag_host_d;
  logic              overrun_q, overrun_d;

  logic              host_ready_c;
  logic              mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] rdata;
  logic              last_word;

  assign last_word = (idx_q == LB_AW'(WORDS_PER_LINE - 1));
  assign rdata     = bus.mem_rdata;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    idx_d        = idx_q;
    tag_idx_d    = tag_idx_q;
    tag_fetch_d  = 1'b0;
    tag_host_d   = 1'b0;
    overrun_d    = 1'b0;
    host_ready_c = 1'b0;
    mem_en_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = bus.host_addr;
    mem_wdata_c  = bus.host_wdata;
    case (state_q)
      IDLE: begin
        host_ready_c = 1'b1;
        mem_en_c     = bus.host_valid;
        mem_we_c     = bus.host_valid & bus.host_we;
        tag_host_d   = bus.host_valid & ~bus.host_we;
        if (bus.fetch_start) begin
          // Product wraps modulo 2^ADDR_W by truncation.
          base_d  = ADDR_W'(bus.fetch_line) * ADDR_W'(WORDS_PER_LINE);
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_en_c    = 1'b1;
        mem_addr_c  = base_q + ADDR_W'(idx_q);
        tag_fetch_d = 1'b1;
        tag_idx_d   = idx_q;
        idx_d       = idx_q + LB_AW'(1);
        overrun_d   = bus.fetch_start;
        if (last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      tag_idx_q   <= '0;
      tag_fetch_q <= 1'b0;
      tag_host_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      tag_idx_q   <= tag_idx_d;
      tag_fetch_q <= tag_fetch_d;
      tag_host_q  <= tag_host_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.fetch_busy    = (state_q == FETCH);
  assign bus.fetch_done    = tag_fetch_q && (tag_idx_q == LB_AW'(WORDS_PER_LINE - 1));
  assign bus.fetch_overrun = overrun_q;
  assign bus.lb_we         = tag_fetch_q;
  assign bus.lb_addr       = tag_idx_q;
  assign bus.lb_wdata      = rdata;
  assign bus.host_ready    = host_ready_c;
  assign bus.host_rvalid   = tag_host_q;
  assign bus.host_rdata    = rdata;
  assign bus.mem_en        = mem_en_c;
  assign bus.mem_we        = mem_we_c;
  assign bus.mem_addr      = mem_addr_c;
  assign bus.mem_wdata     = mem_wdata_c;
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb/tb_vram_scan_arbiter.sv - directed self-checking bench for vram_scan_arbiter with a VRAM model
module tb_vram_scan_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] vram [0:131071];

  vram_scan_arbiter_if #(.ADDR_W(17), .DATA_W(16), .LB_AW(8)) bus ();

  vram_scan_arbiter #(
    .ADDR_W(17), .DATA_W(16), .WORDS_PER_LINE(200), .LB_AW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= vram[bus.mem_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a rising edge; fetch_start is driven for cycle T here.
  task automatic burst(input int line, input int ov_at, input int hr_at, input logic [15:0] hr_exp);
    logic [16:0] base;
    base = 17'((line * 200) % 131072);
    bus.fetch_start = 1'b1;
    bus.fetch_line  = 10'(line);
    @(negedge clk);
    chk("start_host_ready", 32'(bus.host_ready), 32'd1);
    chk("start_busy", 32'(bus.fetch_busy), 32'd0);
    chk("start_mem_en", 32'(bus.mem_en), 32'(bus.host_valid));
    for (int c = 1; c <= 203; c++) begin
      next_cycle();
      bus.fetch_start = (c == ov_at);
      bus.fetch_line  = 10'd7;
      if (hr_at > 0 && c >= hr_at && c <= 201) begin
        bus.host_valid = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 17'h00010;
      end else begin
        bus.host_valid = 1'b0;
        bus.host_we    = 1'b0;
      end
      @(negedge clk);
      chk("busy", 32'(bus.fetch_busy), 32'(c <= 200));
      chk("lb_we", 32'(bus.lb_we), 32'(c >= 2 && c <= 201));
      if (c >= 2 && c <= 201) begin
        chk("lb_addr", 32'(bus.lb_addr), 32'(c - 2));
        chk("lb_wdata", 32'(bus.lb_wdata), 32'(16'(base + 17'(c - 2))));
      end
      if (c <= 200) begin
        chk("fetch_mem_en", 32'(bus.mem_en), 32'd1);
        chk("fetch_mem_we", 32'(bus.mem_we), 32'd0);
        chk("fetch_mem_addr", 32'(bus.mem_addr), 32'(base + 17'(c - 1)));
      end else if (hr_at > 0 && c == 201) begin
        chk("host_rd_mem_en", 32'(bus.mem_en), 32'd1);
        chk("host_rd_mem_we", 32'(bus.mem_we), 32'd0);
        chk("host_rd_mem_addr", 32'(bus.mem_addr), 32'h10);
      end else begin
        chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
      end
      chk("fetch_done", 32'(bus.fetch_done), 32'(c == 201));
      chk("host_ready", 32'(bus.host_ready), 32'(c >= 201));
      chk("fetch_overrun", 32'(bus.fetch_overrun), 32'(ov_at > 0 && c == ov_at + 1));
      chk("host_rvalid", 32'(bus.host_rvalid), 32'(hr_at > 0 && c == 202));
      if (hr_at > 0 && c == 202) chk("host_rdata", 32'(bus.host_rdata), 32'(hr_exp));
    end
  endtask

  initial begin
    for (int a = 0; a < 131072; a++) vram[a] = 16'(a);
    rst             = 1'b1;
    bus.fetch_start = 1'b1;
    bus.fetch_line  = 10'd3;
    bus.host_valid  = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
    bus.mem_rdata   = '0;

    // Reset held two cycles with fetch_start asserted throughout.
    repeat (2) @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.fetch_start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.fetch_busy), 32'd0);
    chk("rst_done", 32'(bus.fetch_done), 32'd0);
    chk("rst_overrun", 32'(bus.fetch_overrun), 32'd0);
    chk("rst_lb_we", 32'(bus.lb_we), 32'd0);
    chk("rst_lb_addr", 32'(bus.lb_addr), 32'd0);
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_host_ready", 32'(bus.host_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("rst_no_burst", 32'(bus.fetch_busy), 32'd0);
      chk("rst_no_lb_we", 32'(bus.lb_we), 32'd0);
    end

    // Idle host write then read-back.
    next_cycle();
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 17'h1FFFF;
    bus.host_wdata = 16'hA5A5;
    @(negedge clk);
    chk("hw_mem_en", 32'(bus.mem_en), 32'd1);
    chk("hw_mem_we", 32'(bus.mem_we), 32'd1);
    chk("hw_mem_addr", 32'(bus.mem_addr), 32'h1FFFF);
    chk("hw_mem_wdata", 32'(bus.mem_wdata), 32'hA5A5);
    chk("hw_rvalid", 32'(bus.host_rvalid), 32'd0);
    next_cycle();
    bus.host_we = 1'b0;
    @(negedge clk);
    chk("hr_mem_en", 32'(bus.mem_en), 32'd1);
    chk("hr_mem_we", 32'(bus.mem_we), 32'd0);
    chk("hr_host_ready", 32'(bus.host_ready), 32'd1);
    next_cycle();
    bus.host_valid = 1'b0;
    @(negedge clk);
    chk("hr_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("hr_rdata", 32'(bus.host_rdata), 32'hA5A5);
    next_cycle();
    @(negedge clk);
    chk("hr_rvalid_drop", 32'(bus.host_rvalid), 32'd0);

    // Plain bursts: first line, last visible line, and a base that wraps the address space.
    next_cycle();
    burst(0, 0, 0, 16'h0);
    next_cycle();
    burst(599, 0, 0, 16'h0);
    next_cycle();
    burst(1023, 0, 0, 16'h0);

    // Host write concurrent with fetch_start, then a read stalled across the burst.
    next_cycle();
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 17'h00010;
    bus.host_wdata = 16'hBEEF;
    burst(1, 0, 5, 16'hBEEF);

    // Rejected fetch_start mid-burst.
    next_cycle();
    burst(2, 50, 0, 16'h0);

    // Reset asserted mid-burst for two cycles.
    next_cycle();
    bus.fetch_start = 1'b1;
    bus.fetch_line  = 10'd4;
    for (int c = 1; c <= 110; c++) begin
      next_cycle();
      bus.fetch_start = 1'b0;
      rst = (c == 100 || c == 101);
      @(negedge clk);
      if (c >= 101) begin
        chk("mrst_lb_we", 32'(bus.lb_we), 32'd0);
        chk("mrst_done", 32'(bus.fetch_done), 32'd0);
        chk("mrst_busy", 32'(bus.fetch_busy), 32'd0);
        chk("mrst_rvalid", 32'(bus.host_rvalid), 32'd0);
      end else begin
        chk("mrst_pre_lb_we", 32'(bus.lb_we), 32'(c >= 2));
      end
    end
    next_cycle();
    burst(3, 0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_scan_arbiter.md
# vram_scan_arbiter

Arbitrates a single-port, synchronous-read video RAM between two requesters: the display line prefetcher and a host read/write port. On each `fetch_start` pulse it bursts one scanline (`WORDS_PER_LINE` words) from VRAM into the display line buffer with absolute priority. Host accesses are served only in idle cycles. It sits between the 800x600 VGA timing generator, which issues `fetch_start` during horizontal blanking, and the VRAM and line buffer.

## Interface
- `ADDR_W`, 17: VRAM word-address width.
- `DATA_W`, 16: VRAM word width (4 pixels x 4-bit index).
- `WORDS_PER_LINE`, 200: words fetched per scanline; also the line stride.
- `LB_AW`, 8: line-buffer address width; must satisfy 2^LB_AW >= WORDS_PER_LINE.

Ports:
- `clk`  in  1  VGA pixel clock. One clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_start`  in  1  one-cycle request to prefetch line `fetch_line`.
- `fetch_line`  in  10  line number, sampled when `fetch_start`=1.
- `fetch_busy`  out  1  burst in progress.
- `fetch_done`  out  1  one-cycle pulse on the final line-buffer write.
- `fetch_overrun`  out  1  one-cycle pulse when `fetch_start` is rejected.
- `lb_we`  out  1  line-buffer write enable.
- `lb_addr`  out  LB_AW  line-buffer word index.
- `lb_wdata`  out  DATA_W  line-buffer data, equal to `mem_rdata`.
- `host_valid`  in  1  host request.
- `host_ready`  out  1  host request accepted this cycle if `host_valid`=1.
- `host_we`  in  1  1=write, 0=read.
- `host_addr`  in  ADDR_W  host word address.
- `host_wdata`  in  DATA_W  host write data.
- `host_rvalid`  out  1  `host_rdata` is valid this cycle.
- `host_rdata`  out  DATA_W  read data, equal to `mem_rdata`.
- `mem_en`, `mem_we`  out  1  VRAM port enable and write enable.
- `mem_addr`  out  ADDR_W  VRAM address.
- `mem_wdata`  out  DATA_W  VRAM write data.
- `mem_rdata`  in  DATA_W  VRAM read data, valid the cycle after a read issue.

## Operation
- States: IDLE and FETCH. Reset enters IDLE.
- **IDLE:**
  - `host_ready`=1.
  - The VRAM port is driven combinationally from the host: `mem_en`=`host_valid`, `mem_we`=`host_we`, and address and data pass through.
- **Fetch start:**
  - `fetch_start` in IDLE registers `base = fetch_line * WORDS_PER_LINE`, truncated to ADDR_W and wrapping modulo 2^ADDR_W.
  - Clears the word counter `idx`.
  - Next state is FETCH.
  - A host access in the same cycle is still accepted.
- **FETCH:**
  - `host_ready`=0; host inputs are ignored.
  - Each cycle issues a read: `mem_en`=1, `mem_we`=0, `mem_addr=base+idx`; then `idx` increments.
  - After the issue with `idx=WORDS_PER_LINE-1`, the next state is IDLE.
- **Return tag pipeline:**
  - A 1-cycle pipeline records the owner of each read (fetch or host) and the `idx` of fetch reads.
  - Fetch return: `lb_we`=1 and `lb_addr` is the tagged `idx`.
  - Host read return: `host_rvalid`=1.
  - Host writes produce no return.
- **Fetch end:**
  - `fetch_done` pulses together with the `lb_we` for `idx=WORDS_PER_LINE-1`.
  - This cycle is already IDLE, so a host access may issue in it.
- **Rejected fetch:** `fetch_start` while in FETCH is ignored; `fetch_overrun` pulses the next cycle and the current burst is unaffected.
- **Mid-burst reset:** `rst` forces IDLE and clears the tag pipeline. No `lb_we`, `host_rvalid`, or `fetch_done` is produced for in-flight reads.
- **Reset values:**
  - 0: `fetch_busy`, `fetch_done`, `fetch_overrun`, `lb_we`, `lb_addr`, `host_rvalid`, `mem_en`, `mem_we`.
  - 1: `host_ready`.
  - Data outputs are don't-care.

## Timing
- `fetch_start` accepted at cycle T:
  - `fetch_busy`=1 for T+1..T+WORDS_PER_LINE.
  - Reads are issued at T+1..T+WORDS_PER_LINE.
  - `lb_we` is high for T+2..T+WORDS_PER_LINE+1.
  - `fetch_done` pulses at T+WORDS_PER_LINE+1.
  - `host_ready` returns to 1 at T+WORDS_PER_LINE+1.
- A burst occupies 201 cycles at default parameters, within the 256-cycle horizontal blanking of 800x600.
- **Host accesses:**
  - Write accepted at cycle A commits to VRAM at A.
  - Read accepted at A returns with `host_rvalid`=1 at A+1.
  - A host request held during FETCH waits with no drop, and is accepted in the first IDLE cycle.
- **Back-to-back fetches:** `fetch_start` at T+WORDS_PER_LINE+1 is legal and starts the next burst at T+WORDS_PER_LINE+2.

## Test plan
- **Reset:** after `rst`=1 for 2 cycles, all control outputs are 0 and `host_ready`=1. `fetch_start` during reset produces no burst.
- **Fetch line 0:**
  - Preload VRAM with mem[a]=a[15:0], then pulse `fetch_start` with `fetch_line`=0 at T.
  - Expect 200 `lb_we` pulses at T+2..T+201 with `lb_addr` i and data i.
  - Expect `fetch_done` at T+201.
- **Fetch line 599:** the first read issues at `mem_addr`=119800 and the last at 119999; `lb_addr` runs 0..199.
- **Host during fetch:**
  - Issue a write to 0x00010 at T, concurrent with `fetch_start`; it commits at T.
  - Issue a read of 0x00010 at T+5; it stalls, is accepted at T+201, and returns `host_rvalid` at T+202 with the written data.
- **Overrun:** `fetch_start` at T+50 during a burst produces `fetch_overrun` at T+51; the first burst completes unchanged with exactly 200 writes.
- **Mid-burst reset:** `rst` at T+100 gives `lb_we`=0 from T+101 onward, with no `fetch_done`. A new `fetch_start` after reset fetches a full 200 words.
